// File: rtl/axi_csr_responder.sv
// AXI4 slave register bank: N_REGS x 32-bit control/status registers with
// independent read and write state machines sharing one register array.
module axi_csr_responder #(
    parameter int                            S_AXI_DATA_WIDTH = 32,
    parameter int                            S_AXI_ADDR_WIDTH = 40,
    parameter int                            S_AXI_ID_WIDTH   = 6,
    parameter int                            N_REGS           = 16,
    parameter logic [S_AXI_ADDR_WIDTH-1:0]   BASE_ADDR        = 40'hA0000000
) (
    input  logic                                   clk,
    input  logic                                   rstn,

    input  logic [S_AXI_ID_WIDTH-1:0]              s_axi_awid,
    input  logic [S_AXI_ADDR_WIDTH-1:0]            s_axi_awaddr,
    input  logic [7:0]                             s_axi_awlen,
    input  logic [2:0]                             s_axi_awsize,
    input  logic [1:0]                             s_axi_awburst,
    input  logic                                   s_axi_awlock,
    input  logic [3:0]                             s_axi_awcache,
    input  logic [2:0]                             s_axi_awprot,
    input  logic                                   s_axi_awvalid,
    output logic                                   s_axi_awready,

    input  logic [S_AXI_DATA_WIDTH-1:0]            s_axi_wdata,
    input  logic [S_AXI_DATA_WIDTH/8-1:0]          s_axi_wstrb,
    input  logic                                   s_axi_wlast,
    input  logic                                   s_axi_wvalid,
    output logic                                   s_axi_wready,

    output logic [S_AXI_ID_WIDTH-1:0]              s_axi_bid,
    output logic [1:0]                             s_axi_bresp,
    output logic                                   s_axi_bvalid,
    input  logic                                   s_axi_bready,

    input  logic [S_AXI_ID_WIDTH-1:0]              s_axi_arid,
    input  logic [S_AXI_ADDR_WIDTH-1:0]            s_axi_araddr,
    input  logic [7:0]                             s_axi_arlen,
    input  logic [2:0]                             s_axi_arsize,
    input  logic [1:0]                             s_axi_arburst,
    input  logic                                   s_axi_arlock,
    input  logic [3:0]                             s_axi_arcache,
    input  logic [2:0]                             s_axi_arprot,
    input  logic                                   s_axi_arvalid,
    output logic                                   s_axi_arready,

    output logic [S_AXI_ID_WIDTH-1:0]              s_axi_rid,
    output logic [S_AXI_DATA_WIDTH-1:0]            s_axi_rdata,
    output logic [1:0]                             s_axi_rresp,
    output logic                                   s_axi_rlast,
    output logic                                   s_axi_rvalid,
    input  logic                                   s_axi_rready,

    output logic [N_REGS-1:0][S_AXI_DATA_WIDTH-1:0] reg_q,
    output logic [N_REGS-1:0]                      reg_wen
);

    localparam int AW = S_AXI_ADDR_WIDTH;
    localparam int DW = S_AXI_DATA_WIDTH;
    localparam int IW = (N_REGS > 1) ? $clog2(N_REGS) : 1;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [2:0] SIZE_WORD   = 3'd2;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    w_state_t w_state, w_next;
    r_state_t r_state, r_next;

    logic [N_REGS-1:0][DW-1:0] regs;

    // Write-channel context
    logic [S_AXI_ID_WIDTH-1:0] awid_q;
    logic [AW-1:0]             waddr_q;
    logic [7:0]                wlen_q;
    logic [2:0]                wsize_q;
    logic [1:0]                wburst_q;
    logic [8:0]                wcnt_q;
    logic                      werr_q;

    // Read-channel context
    logic [S_AXI_ID_WIDTH-1:0] rid_q;
    logic [AW-1:0]             raddr_q;
    logic [7:0]                rlen_q;
    logic [2:0]                rsize_q;
    logic [1:0]                rburst_q;
    logic [7:0]                rbeat_q;
    logic [DW-1:0]             rdata_q;
    logic [1:0]                rresp_q;

    logic aw_fire, w_fire, ar_fire, r_fire;

    logic          unused_attrs;
    assign unused_attrs = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot,
                            s_axi_arlock, s_axi_arcache, s_axi_arprot};

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [AW-1:0] wr_word;
    logic          wr_ok;
    logic [IW-1:0] wr_idx;
    logic [AW-1:0] wr_next_addr;

    assign wr_word      = (waddr_q - BASE_ADDR) >> 2;
    assign wr_ok        = (wsize_q == SIZE_WORD) && (waddr_q >= BASE_ADDR) &&
                          (wr_word < AW'(N_REGS));
    assign wr_idx       = wr_word[IW-1:0];
    assign wr_next_addr = (wburst_q == BURST_FIXED) ? waddr_q : waddr_q + AW'(4);

    // The read decoder looks at the AR address while idle and at the next
    // burst address while streaming, so rdata is always preloaded one beat ahead.
    logic [AW-1:0] rd_next_addr;
    logic [AW-1:0] rd_addr;
    logic [2:0]    rd_size;
    logic [AW-1:0] rd_word;
    logic          rd_ok;
    logic [IW-1:0] rd_idx;
    logic [DW-1:0] rd_data;
    logic [1:0]    rd_resp;

    assign rd_next_addr = (rburst_q == BURST_FIXED) ? raddr_q : raddr_q + AW'(4);
    assign rd_addr      = (r_state == R_IDLE) ? s_axi_araddr : rd_next_addr;
    assign rd_size      = (r_state == R_IDLE) ? s_axi_arsize : rsize_q;
    assign rd_word      = (rd_addr - BASE_ADDR) >> 2;
    assign rd_ok        = (rd_size == SIZE_WORD) && (rd_addr >= BASE_ADDR) &&
                          (rd_word < AW'(N_REGS));
    assign rd_idx       = rd_word[IW-1:0];
    assign rd_data      = rd_ok ? regs[rd_idx] : '0;
    assign rd_resp      = rd_ok ? RESP_OKAY : RESP_SLVERR;

    // ------------------------------------------------------------------
    // Write FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_next;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_next        = w_state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        case (w_state)
            W_IDLE: begin
                s_axi_awready = 1'b1;
                if (s_axi_awvalid) w_next = W_DATA;
            end
            W_DATA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid && s_axi_wlast) w_next = W_RESP;
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    assign aw_fire     = s_axi_awvalid && s_axi_awready;
    assign w_fire      = s_axi_wvalid && s_axi_wready;
    assign s_axi_bid   = awid_q;
    assign s_axi_bresp = (s_axi_bvalid && werr_q) ? RESP_SLVERR : RESP_OKAY;

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            awid_q   <= '0;
            waddr_q  <= '0;
            wlen_q   <= '0;
            wsize_q  <= '0;
            wburst_q <= '0;
            wcnt_q   <= '0;
            werr_q   <= 1'b0;
        end else if (aw_fire) begin
            awid_q   <= s_axi_awid;
            waddr_q  <= s_axi_awaddr;
            wlen_q   <= s_axi_awlen;
            wsize_q  <= s_axi_awsize;
            wburst_q <= s_axi_awburst;
            wcnt_q   <= '0;
            werr_q   <= 1'b0;
        end else if (w_fire) begin
            waddr_q <= wr_next_addr;
            if (wcnt_q != '1) wcnt_q <= wcnt_q + 9'd1;
            // wcnt_q counts beats before this one, so a correct burst ends at wcnt_q == len
            werr_q  <= werr_q || !wr_ok || (s_axi_wlast && (wcnt_q != {1'b0, wlen_q}));
        end
    end

    // NOTE: the register array is reset explicitly because its contents are architecturally visible on reg_q from the first cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            regs    <= '0;
            reg_wen <= '0;
        end else begin
            reg_wen <= '0;
            if (w_fire && wr_ok) begin
                for (int b = 0; b < DW / 8; b++) begin
                    if (s_axi_wstrb[b]) regs[wr_idx][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                end
                reg_wen[wr_idx] <= |s_axi_wstrb;
            end
        end
    end

    assign reg_q = regs;

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_next;
        end
    end

    always_comb begin
        r_next        = r_state;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        case (r_state)
            R_IDLE: begin
                s_axi_arready = 1'b1;
                if (s_axi_arvalid) r_next = R_DATA;
            end
            R_DATA: begin
                s_axi_rvalid = 1'b1;
                if (s_axi_rready && s_axi_rlast) r_next = R_IDLE;
            end
            default: r_next = R_IDLE;
        endcase
    end

    assign ar_fire     = s_axi_arvalid && s_axi_arready;
    assign r_fire      = s_axi_rvalid && s_axi_rready;
    assign s_axi_rlast = s_axi_rvalid && (rbeat_q == rlen_q);
    assign s_axi_rid   = rid_q;
    assign s_axi_rdata = rdata_q;
    assign s_axi_rresp = rresp_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rid_q    <= '0;
            raddr_q  <= '0;
            rlen_q   <= '0;
            rsize_q  <= '0;
            rburst_q <= '0;
            rbeat_q  <= '0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (ar_fire) begin
            rid_q    <= s_axi_arid;
            raddr_q  <= s_axi_araddr;
            rlen_q   <= s_axi_arlen;
            rsize_q  <= s_axi_arsize;
            rburst_q <= s_axi_arburst;
            rbeat_q  <= '0;
            rdata_q  <= rd_data;
            rresp_q  <= rd_resp;
        end else if (r_fire) begin
            if (s_axi_rlast) begin
                rdata_q <= '0;
                rresp_q <= RESP_OKAY;
            end else begin
                raddr_q <= rd_next_addr;
                rbeat_q <= rbeat_q + 8'd1;
                rdata_q <= rd_data;
                rresp_q <= rd_resp;
            end
        end
    end

endmodule
